// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM unified-memory port arbiter:
// FSM state encoding and byte-enable width helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    D_BUSY  = 2'd1,
    IF_BUSY = 2'd2,
    IF_DROP = 2'd3
  } state_e;

  function automatic int unsigned be_width(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/memarb_stall_cnt.sv
// Single wrapping stall-cycle counter for the memory port arbiter.
// Only present when MEMARB_PERF_CNT_EN is defined.
`ifdef MEMARB_PERF_CNT_EN
module memarb_stall_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count one per stalled cycle; natural overflow gives the wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (inc) cnt_d = cnt_q + CNT_W'(1);
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port, variable-latency memory between the
// IF stage (fetch) and the MEM stage (load/store). One transaction at a
// time, MEM has priority, killed fetches complete silently.
// Optional stall-cycle counters: define MEMARB_PERF_CNT_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                IF_REQ,
  input  logic [ADDR_W-1:0]   IF_ADDR,
  input  logic                IF_FLUSH,
  output logic                IF_VALID,
  output logic [DATA_W-1:0]   IF_RDATA,
  output logic                IF_STALL,
  input  logic                D_REQ,
  input  logic                D_WE,
  input  logic [DATA_W/8-1:0] D_BE,
  input  logic [ADDR_W-1:0]   D_ADDR,
  input  logic [DATA_W-1:0]   D_WDATA,
  output logic                D_VALID,
  output logic [DATA_W-1:0]   D_RDATA,
  output logic                D_STALL,
  output logic                M_REQ,
  output logic                M_WE,
  output logic [DATA_W/8-1:0] M_BE,
  output logic [ADDR_W-1:0]   M_ADDR,
  output logic [DATA_W-1:0]   M_WDATA,
  input  logic                M_READY,
  input  logic [DATA_W-1:0]   M_RDATA
`ifdef MEMARB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    IF_STALL_CNT,
  output logic [CNT_W-1:0]    D_STALL_CNT
`endif
);

  localparam int unsigned BE_W = be_width(DATA_W);

  state_e              state_q, state_d;
  logic                m_req_q, m_req_d;
  logic                m_we_q, m_we_d;
  logic [BE_W-1:0]     m_be_q, m_be_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic                if_valid_q, if_valid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                d_valid_q, d_valid_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  // Next-state and registered-output logic. A requester whose VALID is
  // pulsing this cycle still shows its old REQ, so it is not re-granted.
  always_comb begin
    state_d    = state_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_be_d     = m_be_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_valid_d = 1'b0;
    if_rdata_d = if_rdata_q;
    d_valid_d  = 1'b0;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (D_REQ && !d_valid_q) begin
          m_req_d   = 1'b1;
          m_we_d    = D_WE;
          m_be_d    = D_BE;
          m_addr_d  = D_ADDR;
          m_wdata_d = D_WDATA;
          state_d   = D_BUSY;
        end else if (IF_REQ && !IF_FLUSH && !if_valid_q) begin
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_be_d    = '1;
          m_addr_d  = IF_ADDR;
          state_d   = IF_BUSY;
        end
      end
      D_BUSY: begin
        if (M_READY) begin
          m_req_d   = 1'b0;
          d_valid_d = 1'b1;
          if (!m_we_q) d_rdata_d = M_RDATA;
          state_d   = IDLE;
        end
      end
      IF_BUSY: begin
        if (M_READY) begin
          m_req_d = 1'b0;
          if (!IF_FLUSH) begin
            if_valid_d = 1'b1;
            if_rdata_d = M_RDATA;
          end
          state_d = IDLE;
        end else if (IF_FLUSH) begin
          state_d = IF_DROP;
        end
      end
      IF_DROP: begin
        if (M_READY) begin
          m_req_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and output registers; reset abandons any in-flight request.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_be_q     <= '0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_valid_q <= 1'b0;
      if_rdata_q <= '0;
      d_valid_q  <= 1'b0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_be_q     <= m_be_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_valid_q <= if_valid_d;
      if_rdata_q <= if_rdata_d;
      d_valid_q  <= d_valid_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign M_REQ    = m_req_q;
  assign M_WE     = m_we_q;
  assign M_BE     = m_be_q;
  assign M_ADDR   = m_addr_q;
  assign M_WDATA  = m_wdata_q;
  assign IF_VALID = if_valid_q;
  assign IF_RDATA = if_rdata_q;
  assign D_VALID  = d_valid_q;
  assign D_RDATA  = d_rdata_q;
  assign IF_STALL = IF_REQ & ~if_valid_q;
  assign D_STALL  = D_REQ & ~d_valid_q;

`ifdef MEMARB_PERF_CNT_EN
  memarb_stall_cnt #(.CNT_W(CNT_W)) u_if_stall_cnt (
    .clk (CLK),
    .rst (RST),
    .inc (IF_STALL),
    .cnt (IF_STALL_CNT)
  );

  memarb_stall_cnt #(.CNT_W(CNT_W)) u_d_stall_cnt (
    .clk (CLK),
    .rst (RST),
    .inc (D_STALL),
    .cnt (D_STALL_CNT)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers push expected responses
// and memory commands into queues; a memory responder and a VALID
// monitor pop and compare. Counter checks need MEMARB_PERF_CNT_EN.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IF_REQ, IF_FLUSH;
  logic [31:0] IF_ADDR;
  logic        IF_VALID, IF_STALL;
  logic [31:0] IF_RDATA;
  logic        D_REQ, D_WE;
  logic [3:0]  D_BE;
  logic [31:0] D_ADDR, D_WDATA;
  logic        D_VALID, D_STALL;
  logic [31:0] D_RDATA;
  logic        M_REQ, M_WE;
  logic [3:0]  M_BE;
  logic [31:0] M_ADDR, M_WDATA;
  logic        M_READY;
  logic [31:0] M_RDATA;
`ifdef MEMARB_PERF_CNT_EN
  logic [3:0]  IF_STALL_CNT, D_STALL_CNT;
`endif

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_FLUSH(IF_FLUSH),
    .IF_VALID(IF_VALID), .IF_RDATA(IF_RDATA), .IF_STALL(IF_STALL),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_BE(D_BE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_VALID(D_VALID), .D_RDATA(D_RDATA), .D_STALL(D_STALL),
    .M_REQ(M_REQ), .M_WE(M_WE), .M_BE(M_BE), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA),
    .M_READY(M_READY), .M_RDATA(M_RDATA)
`ifdef MEMARB_PERF_CNT_EN
    , .IF_STALL_CNT(IF_STALL_CNT), .D_STALL_CNT(D_STALL_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] if_exp[$];
  logic [31:0] d_exp[$];
  cmd_t        cmd_exp[$];
  logic [31:0] mem [logic [31:0]];
  int          lat = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory responder: checks each new command, holds it for lat cycles.
  cmd_t cur;
  int   cnt;
  bit   in_flight;

  task automatic respond();
    logic [31:0] w;
    M_READY = 1'b1;
    if (M_WE) begin
      w = mem.exists(M_ADDR) ? mem[M_ADDR] : 32'h0;
      for (int unsigned b = 0; b < 4; b++)
        if (M_BE[b]) w[8*b +: 8] = M_WDATA[8*b +: 8];
      mem[M_ADDR] = w;
      M_RDATA = 32'hBAD0BAD0;
    end else begin
      M_RDATA = mem.exists(M_ADDR) ? mem[M_ADDR] : 32'hDEAD0000;
    end
  endtask

  initial begin
    M_READY = 1'b0;
    M_RDATA = '0;
    in_flight = 1'b0;
    cnt = 0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        M_READY = 1'b0;
        in_flight = 1'b0;
      end else if (M_READY) begin
        M_READY = 1'b0;
        in_flight = 1'b0;
        chk("m_req_drop", {31'b0, M_REQ}, 32'h0);
      end else if (in_flight) begin
        chk("m_addr_stable", M_ADDR, cur.addr);
        chk("m_we_stable", {31'b0, M_WE}, {31'b0, cur.we});
        cnt--;
        if (cnt <= 0) respond();
      end else if (M_REQ) begin
        if (cmd_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL m_cmd: got unexpected request addr 0x%08h expected none", M_ADDR);
          cur.we = M_WE;
          cur.addr = M_ADDR;
        end else begin
          cur = cmd_exp.pop_front();
          chk("m_addr", M_ADDR, cur.addr);
          chk("m_we", {31'b0, M_WE}, {31'b0, cur.we});
          chk("m_be", {28'b0, M_BE}, {28'b0, cur.be});
          if (cur.we) chk("m_wdata", M_WDATA, cur.wdata);
        end
        in_flight = 1'b1;
        cnt = lat;
        if (cnt <= 0) respond();
      end
    end
  end

  // VALID monitor: every pulse must match the next expected response.
  initial begin
    forever begin
      @(negedge CLK);
      if (!RST && IF_VALID) begin
        if (if_exp.size() == 0) begin
          checks++; errors++;
          $display("FAIL if_valid: got unexpected pulse rdata 0x%08h expected none", IF_RDATA);
        end else chk("if_rdata", IF_RDATA, if_exp.pop_front());
      end
      if (!RST && D_VALID) begin
        if (d_exp.size() == 0) begin
          checks++; errors++;
          $display("FAIL d_valid: got unexpected pulse rdata 0x%08h expected none", D_RDATA);
        end else chk("d_rdata", D_RDATA, d_exp.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Wait (bounded) for the chosen VALID, checking STALL every cycle.
  task automatic wait_valid(input bit is_d, output int cyc);
    logic v;
    cyc = 0;
    do begin
      @(posedge CLK); #1;
      cyc++;
      v = is_d ? D_VALID : IF_VALID;
      if (is_d) chk("d_stall", {31'b0, D_STALL}, {31'b0, !v});
      else      chk("if_stall", {31'b0, IF_STALL}, {31'b0, !v});
    end while (!v && cyc < 60);
    if (!v) begin
      checks++; errors++;
      $display("FAIL valid_timeout: got no VALID expected pulse (is_d=%0d)", is_d);
    end
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] data, input int l);
    int cyc;
    mem[a] = data;
    lat = l;
    if_exp.push_back(data);
    cmd_exp.push_back('{1'b0, 4'hF, a, 32'h0});
    IF_ADDR = a;
    IF_REQ = 1'b1;
    wait_valid(1'b0, cyc);
    chk("if_latency", cyc, l + 2);
    @(posedge CLK); #1;
    IF_REQ = 1'b0;
  endtask

  task automatic dacc(input logic we, input logic [3:0] be, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input int l);
    int cyc;
    lat = l;
    d_exp.push_back(exp_rd);
    cmd_exp.push_back('{we, be, a, wd});
    D_WE = we; D_BE = be; D_ADDR = a; D_WDATA = wd;
    D_REQ = 1'b1;
    wait_valid(1'b1, cyc);
    chk("d_latency", cyc, l + 2);
    @(posedge CLK); #1;
    D_REQ = 1'b0;
  endtask

  initial begin
    int cyc;
    RST = 1'b1;
    IF_REQ = 1'b0; IF_ADDR = '0; IF_FLUSH = 1'b0;
    D_REQ = 1'b0; D_WE = 1'b0; D_BE = '0; D_ADDR = '0; D_WDATA = '0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    // Reset state
    chk("rst_m_req", {31'b0, M_REQ}, 32'h0);
    chk("rst_m_we", {31'b0, M_WE}, 32'h0);
    chk("rst_m_be", {28'b0, M_BE}, 32'h0);
    chk("rst_m_addr", M_ADDR, 32'h0);
    chk("rst_m_wdata", M_WDATA, 32'h0);
    chk("rst_if_valid", {31'b0, IF_VALID}, 32'h0);
    chk("rst_d_valid", {31'b0, D_VALID}, 32'h0);
    chk("rst_if_rdata", IF_RDATA, 32'h0);
    chk("rst_d_rdata", D_RDATA, 32'h0);

    // 1. Fetch only, READY 2 cycles after M_REQ
    fetch(32'h40, 32'h00500093, 2);

`ifdef MEMARB_PERF_CNT_EN
    // 6. Stall counters: 4 stalls, then 12 more wraps a 4-bit counter to 0
    chk("if_stall_cnt_4", {28'b0, IF_STALL_CNT}, 32'd4);
    chk("d_stall_cnt_0", {28'b0, D_STALL_CNT}, 32'd0);
    fetch(32'h48, 32'h00000013, 10);
    chk("if_stall_cnt_wrap", {28'b0, IF_STALL_CNT}, 32'd0);
`endif

    // 2. Collision: MEM first, IF granted while D_VALID pulses
    lat = 1;
    mem[32'h1000] = 32'h11112222;
    mem[32'h44] = 32'h00A00113;
    d_exp.push_back(32'h11112222);
    if_exp.push_back(32'h00A00113);
    cmd_exp.push_back('{1'b0, 4'hF, 32'h1000, 32'h0});
    cmd_exp.push_back('{1'b0, 4'hF, 32'h44, 32'h0});
    D_WE = 1'b0; D_BE = 4'hF; D_ADDR = 32'h1000; D_REQ = 1'b1;
    IF_ADDR = 32'h44; IF_REQ = 1'b1;
    wait_valid(1'b1, cyc);
    chk("coll_d_latency", cyc, 32'd3);
    @(posedge CLK); #1;
    D_REQ = 1'b0;
    chk("coll_if_m_req", {31'b0, M_REQ}, 32'h1);
    chk("coll_if_m_addr", M_ADDR, 32'h44);
    wait_valid(1'b0, cyc);
    chk("coll_if_latency", cyc, 32'd2);
    @(posedge CLK); #1;
    IF_REQ = 1'b0;

    // 3. Store keeps D_RDATA; reload shows the byte-lane merge
    mem[32'h2000] = 32'h12345678;
    dacc(1'b1, 4'b0011, 32'h2000, 32'hDEADBEEF, 32'h11112222, 2);
    dacc(1'b0, 4'hF, 32'h2000, 32'h0, 32'h1234BEEF, 0);

    // 4. Flush one cycle after grant; redirected fetch waits for READY
    lat = 3;
    mem[32'h60] = 32'hAAAA0001;
    mem[32'h80] = 32'h00000013;
    cmd_exp.push_back('{1'b0, 4'hF, 32'h60, 32'h0});
    cmd_exp.push_back('{1'b0, 4'hF, 32'h80, 32'h0});
    if_exp.push_back(32'h00000013);
    IF_ADDR = 32'h60; IF_REQ = 1'b1;
    @(posedge CLK); #1;
    chk("flush_grant_m_req", {31'b0, M_REQ}, 32'h1);
    IF_FLUSH = 1'b1; IF_ADDR = 32'h80;
    @(posedge CLK); #1;
    IF_FLUSH = 1'b0;
    chk("flush_m_addr_held", M_ADDR, 32'h60);
    wait_valid(1'b0, cyc);
    chk("flush_refetch_latency", cyc, 32'd8);
    @(posedge CLK); #1;
    IF_REQ = 1'b0;

    // 4b. Flush in the same cycle as M_READY drops the fetch
    lat = 1;
    mem[32'hA0] = 32'hBBBB0002;
    cmd_exp.push_back('{1'b0, 4'hF, 32'hA0, 32'h0});
    IF_ADDR = 32'hA0; IF_REQ = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    IF_FLUSH = 1'b1;
    @(posedge CLK); #1;
    IF_FLUSH = 1'b0; IF_REQ = 1'b0;
    chk("flush_ready_m_req", {31'b0, M_REQ}, 32'h0);
    chk("flush_ready_if_valid", {31'b0, IF_VALID}, 32'h0);
    repeat (3) @(posedge CLK);
    #1;

    // 5. Reset while D_BUSY, then a normal load with IF_FLUSH held high
    lat = 5;
    mem[32'h3000] = 32'h33334444;
    cmd_exp.push_back('{1'b0, 4'hF, 32'h3000, 32'h0});
    D_WE = 1'b0; D_BE = 4'hF; D_ADDR = 32'h3000; D_REQ = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_mid_m_req_before", {31'b0, M_REQ}, 32'h1);
    #2 RST = 1'b1;
    #1;
    chk("rst_mid_m_req_async", {31'b0, M_REQ}, 32'h0);
    D_REQ = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    chk("rst_mid_no_d_valid", {31'b0, D_VALID}, 32'h0);
    chk("rst_mid_d_rdata", D_RDATA, 32'h0);
    IF_FLUSH = 1'b1;
    dacc(1'b0, 4'hF, 32'h1000, 32'h0, 32'h11112222, 0);
    IF_FLUSH = 1'b0;

    repeat (5) @(posedge CLK);
    #1;
    chk("left_if_exp", if_exp.size(), 32'd0);
    chk("left_d_exp", d_exp.size(), 32'd0);
    chk("left_cmd_exp", cmd_exp.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
